spi_flash_responder: RTL and testbench

SPI mode-0 target that emulates the read-side command set of a serial NOR flash. It lets the bootloader's SPI flash master, or any external SPI host, read a block-RAM or ROM image through the standard flash protocol. The bus pins are oversampled in the `clk` domain. Read data is fetched from an on-chip memory port one byte ahead of the shift-out.

---
 rtl/spi_flash_responder_pkg.sv | 31 +++
 rtl/spi_flash_responder_if.sv | 27 ++
 rtl/spi_flash_responder_pin_sync.sv | 49 ++++
 rtl/spi_flash_responder.sv | 178 +++++++++++++++++
 tb/tb_spi_flash_responder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes and state encoding for the SPI flash responders.
// The program/erase responder is expected to reuse the same state enum.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RES  = 8'hAB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_ID,
        ST_STAT,
        ST_DEVID,
        ST_IGNORE
    } state_e;

    // READ and RES both collect three address/dummy bytes first.
    function automatic state_e opcode_next_state(input logic [7:0] op);
        case (op)
            OP_READ, OP_RES: return ST_ADDR;
            OP_RDID:         return ST_ID;
            OP_RDSR:         return ST_STAT;
            default:         return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins, memory read port and command monitor of the flash responder.
// slave = responder side, master = host/memory side.
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spi_cs;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic [7:0]        status_in;
    logic              cmd_valid;
    logic [7:0]        cmd_byte;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, mem_data, status_in,
        output spi_miso, spi_miso_oe, mem_addr, mem_rd, cmd_valid, cmd_byte
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, mem_data, status_in,
        input  spi_miso, spi_miso_oe, mem_addr, mem_rd, cmd_valid, cmd_byte
    );
endinterface

// File: rtl/spi_flash_responder_pin_sync.sv
// Two-flop synchronisers plus a history flop for cs, sck and mosi,
// with sck edge detection in the clk domain.
module spi_pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic cs_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic cs_n_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic mosi_o
);
    localparam int PIN_MOSI = 0;
    localparam int PIN_SCK  = 1;
    localparam int PIN_CS   = 2;

    logic [2:0] pin_vec;
    assign pin_vec = {cs_i, sck_i, mosi_i};

    // cs resets to "selected" so a select held low across reset is never
    // mistaken for a fresh transaction start.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pin
            logic meta_q;
            logic sync_q;
            logic hist_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    hist_q <= 1'b0;
                end else begin
                    meta_q <= pin_vec[gi];
                    sync_q <= meta_q;
                    hist_q <= sync_q;
                end
            end
        end
    endgenerate

    // Deselect acts at once; select needs two consecutive low samples.
    assign cs_n_o     = g_pin[PIN_CS].sync_q | g_pin[PIN_CS].hist_q;
    assign sck_rise_o = g_pin[PIN_SCK].sync_q & ~g_pin[PIN_SCK].hist_q;
    assign sck_fall_o = ~g_pin[PIN_SCK].sync_q & g_pin[PIN_SCK].hist_q;
    assign mosi_o     = g_pin[PIN_MOSI].hist_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating the read command set of a serial NOR flash,
// serving data from a synchronous memory port prefetched one byte ahead.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  DEV_ID   = 8'h15
) (
    input logic                  clk,
    input logic                  reset,
    spi_flash_responder_if.slave bus
);
    logic cs_n, sck_rise, sck_fall, mosi;

    spi_pin_sync u_pin_sync (
        .clk        (clk),
        .reset      (reset),
        .cs_i       (bus.spi_cs),
        .sck_i      (bus.spi_sck),
        .mosi_i     (bus.spi_mosi),
        .cs_n_o     (cs_n),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .mosi_o     (mosi)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_in_q, shift_in_d;
    logic [7:0]        shift_out_q, shift_out_d;
    logic [23:0]       addr_q, addr_d;
    logic [1:0]        addr_cnt_q, addr_cnt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              load_q, load_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              oe_q, oe_d;
    logic              armed_q, armed_d;
    logic [7:0]        in_byte;
    logic              byte_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            addr_cnt_q  <= '0;
            id_idx_q    <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            load_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            oe_q        <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            addr_cnt_q  <= addr_cnt_d;
            id_idx_q    <= id_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            load_q      <= load_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
            oe_q        <= oe_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        addr_cnt_d  = addr_cnt_q;
        id_idx_d    = id_idx_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        load_d      = mem_rd_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;
        armed_d     = armed_q | cs_n;
        in_byte     = {shift_in_q[6:0], mosi};
        byte_done   = 1'b0;

        if (cs_n) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            shift_out_d = '0;
        end else if (state_q == ST_IDLE) begin
            // Only a select seen high since reset may start a transaction.
            if (armed_q) begin
                state_d = ST_CMD;
            end
        end else begin
            if (sck_rise) begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
                shift_in_d = in_byte;
                byte_done  = (bit_cnt_q == 3'd7);
            end
            // The fall after the 8th rise keeps the freshly loaded bit 7.
            if (sck_fall && bit_cnt_q != 3'd0) begin
                shift_out_d = {shift_out_q[6:0], 1'b0};
            end
            if (load_q && state_q == ST_READ) begin
                shift_out_d = bus.mem_data;
            end
            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        cmd_byte_d  = in_byte;
                        cmd_valid_d = 1'b1;
                        state_d     = opcode_next_state(in_byte);
                        addr_cnt_d  = '0;
                        id_idx_d    = 2'd1;
                        case (in_byte)
                            OP_RDID: shift_out_d = JEDEC_ID[23:16];
                            OP_RDSR: shift_out_d = bus.status_in;
                            default: shift_out_d = '0;
                        endcase
                    end
                    ST_ADDR: begin
                        addr_d      = {addr_q[15:0], in_byte};
                        addr_cnt_d  = addr_cnt_q + 2'd1;
                        shift_out_d = '0;
                        if (addr_cnt_q == 2'd2) begin
                            if (cmd_byte_q == OP_READ) begin
                                mem_addr_d = ADDR_W'(addr_d);
                                mem_rd_d   = 1'b1;
                                state_d    = ST_READ;
                            end else begin
                                state_d     = ST_DEVID;
                                shift_out_d = DEV_ID;
                            end
                        end
                    end
                    ST_READ: begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        mem_rd_d   = 1'b1;
                    end
                    ST_ID: begin
                        case (id_idx_q)
                            2'd1:    shift_out_d = JEDEC_ID[15:8];
                            2'd2:    shift_out_d = JEDEC_ID[7:0];
                            default: shift_out_d = '0;
                        endcase
                        if (id_idx_q != 2'd3) begin
                            id_idx_d = id_idx_q + 2'd1;
                        end
                    end
                    ST_STAT:  shift_out_d = bus.status_in;
                    ST_DEVID: shift_out_d = DEV_ID;
                    default:  shift_out_d = '0;
                endcase
            end
        end

        oe_d = !cs_n && (state_d != ST_IDLE);
    end

    assign bus.spi_miso    = shift_out_q[7];
    assign bus.spi_miso_oe = oe_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_byte    = cmd_byte_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: one SPI host drives two responders (24-bit and 8-bit
// address) in parallel, each with its own synchronous memory model.
module tb_spi_flash_responder;
    localparam int HALF = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cs_drv, sck_drv, mosi_drv;
    logic [7:0] status_val;
    logic [7:0] mem_a_q, mem_b_q;
    int         pass_cnt, total_cnt;
    int         cv_cnt_a;
    logic [23:0] rd_q_a[$];
    logic [7:0]  rd_q_b[$];

    spi_flash_responder_if #(.ADDR_W(24)) bus_a ();
    spi_flash_responder_if #(.ADDR_W(8))  bus_b ();

    assign bus_a.spi_cs    = cs_drv;
    assign bus_a.spi_sck   = sck_drv;
    assign bus_a.spi_mosi  = mosi_drv;
    assign bus_a.status_in = status_val;
    assign bus_a.mem_data  = mem_a_q;
    assign bus_b.spi_cs    = cs_drv;
    assign bus_b.spi_sck   = sck_drv;
    assign bus_b.spi_mosi  = mosi_drv;
    assign bus_b.status_in = status_val;
    assign bus_b.mem_data  = mem_b_q;

    spi_flash_responder #(.ADDR_W(24)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    spi_flash_responder #(.ADDR_W(8))  dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    // Memory A holds mem[0x100+i] = i, anything else reads 0xEE.
    always @(posedge clk) begin
        if (bus_a.mem_rd)
            mem_a_q <= (bus_a.mem_addr[23:8] == 16'h0001) ? bus_a.mem_addr[7:0] : 8'hEE;
        if (bus_b.mem_rd)
            mem_b_q <= bus_b.mem_addr ^ 8'hA5;
    end

    always @(negedge clk) begin
        if (bus_a.cmd_valid) cv_cnt_a++;
        if (bus_a.mem_rd) rd_q_a.push_back(bus_a.mem_addr);
        if (bus_b.mem_rd) rd_q_b.push_back(bus_b.mem_addr);
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx_a, output logic [7:0] rx_b);
        rx_a = '0;
        rx_b = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi_drv = tx[i];
            repeat (HALF) @(posedge clk);
            #1;
            rx_a[i] = bus_a.spi_miso;
            rx_b[i] = bus_b.spi_miso;
            sck_drv = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            sck_drv = 1'b0;
        end
        $display("xfer tx=%02h bits=%0d rx_a=%02h rx_b=%02h", tx, nbits, rx_a, rx_b);
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] ra, rb;
        spi_bits(tx, 8, ra, rb);
    endtask

    task automatic cs_begin();
        @(posedge clk);
        #1 cs_drv = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic cs_end();
        repeat (HALF) @(posedge clk);
        #1 cs_drv = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (bus_a.spi_miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", bus_a.spi_miso); else pass_cnt++;
        total_cnt++;
        if (bus_a.spi_miso_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", bus_a.spi_miso_oe); else pass_cnt++;
        total_cnt++;
        if (bus_a.mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b expected 0", bus_a.mem_rd); else pass_cnt++;
        total_cnt++;
        if (bus_a.mem_addr !== 24'h0) $display("FAIL reset_mem_addr: got %h expected 000000", bus_a.mem_addr); else pass_cnt++;
        total_cnt++;
        if (bus_a.cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b expected 0", bus_a.cmd_valid); else pass_cnt++;
        total_cnt++;
        if (bus_a.cmd_byte !== 8'h00) $display("FAIL reset_cmd_byte: got %h expected 00", bus_a.cmd_byte); else pass_cnt++;
        total_cnt++;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_rdid();
        logic [7:0] exp_id [4] = '{8'hEF, 8'h40, 8'h16, 8'h00};
        logic [7:0] ra, rb;
        int cv0;
        cv0 = cv_cnt_a;
        cs_begin();
        send(8'h9F);
        if (bus_a.spi_miso_oe !== 1'b1) $display("FAIL rdid_oe: got %b expected 1", bus_a.spi_miso_oe); else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, ra, rb);
            if (ra !== exp_id[i]) $display("FAIL rdid_byte%0d: got %02h expected %02h", i, ra, exp_id[i]); else pass_cnt++;
            total_cnt++;
        end
        cs_end();
        if (cv_cnt_a - cv0 !== 1) $display("FAIL rdid_cmd_valid_count: got %0d expected 1", cv_cnt_a - cv0); else pass_cnt++;
        total_cnt++;
        if (bus_a.cmd_byte !== 8'h9F) $display("FAIL rdid_cmd_byte: got %02h expected 9f", bus_a.cmd_byte); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_read();
        logic [7:0] ra, rb;
        rd_q_a.delete();
        cs_begin();
        send(8'h03); send(8'h00); send(8'h01); send(8'h00);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, ra, rb);
            if (ra !== 8'(i)) $display("FAIL read_byte%0d: got %02h expected %02h", i, ra, 8'(i)); else pass_cnt++;
            total_cnt++;
        end
        cs_end();
        if (rd_q_a.size() !== 5) $display("FAIL read_rd_count: got %0d expected 5", rd_q_a.size()); else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < 4 && i < rd_q_a.size(); i++) begin
            if (rd_q_a[i] !== 24'h100 + 24'(i)) $display("FAIL read_addr%0d: got %h expected %h", i, rd_q_a[i], 24'h100 + 24'(i)); else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d [3] = '{8'h5B, 8'h5A, 8'hA5};
        logic [7:0] exp_a [3] = '{8'hFE, 8'hFF, 8'h00};
        logic [7:0] ra, rb;
        rd_q_b.delete();
        cs_begin();
        send(8'h03); send(8'h00); send(8'h00); send(8'hFE);
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, ra, rb);
            if (rb !== exp_d[i]) $display("FAIL wrap_byte%0d: got %02h expected %02h", i, rb, exp_d[i]); else pass_cnt++;
            total_cnt++;
        end
        cs_end();
        if (rd_q_b.size() < 3) begin
            $display("FAIL wrap_rd_count: got %0d expected at least 3", rd_q_b.size());
            total_cnt++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rd_q_b[i] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %02h expected %02h", i, rd_q_b[i], exp_a[i]); else pass_cnt++;
                total_cnt++;
            end
        end
    endtask

    task automatic test_status();
        logic [7:0] ra, rb;
        status_val = 8'h01;
        cs_begin();
        send(8'h05);
        status_val = 8'h00;
        spi_bits(8'h00, 8, ra, rb);
        if (ra !== 8'h01) $display("FAIL status_byte0: got %02h expected 01", ra); else pass_cnt++;
        total_cnt++;
        spi_bits(8'h00, 8, ra, rb);
        if (ra !== 8'h00) $display("FAIL status_byte1: got %02h expected 00", ra); else pass_cnt++;
        total_cnt++;
        cs_end();
    endtask

    task automatic test_ignore();
        logic [7:0] ra, rb;
        int lat;
        cs_begin();
        send(8'h5A);
        for (int i = 0; i < 2; i++) begin
            spi_bits(8'hFF, 8, ra, rb);
            if (ra !== 8'h00) $display("FAIL ignore_byte%0d: got %02h expected 00", i, ra); else pass_cnt++;
            total_cnt++;
        end
        cs_end();
        rd_q_a.delete();
        cs_begin();
        send(8'h03); send(8'h00);
        spi_bits(8'h12, 4, ra, rb);
        mosi_drv = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 sck_drv = 1'b1;
        repeat (2) @(posedge clk);
        #1 cs_drv = 1'b1;
        lat = 9;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (bus_a.spi_miso_oe === 1'b0) begin
                lat = k;
                break;
            end
        end
        if (lat > 4) $display("FAIL ignore_oe_latency: got %0d clk expected at most 4", lat); else pass_cnt++;
        total_cnt++;
        sck_drv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        if (rd_q_a.size() !== 0) $display("FAIL ignore_no_mem_rd: got %0d reads expected 0", rd_q_a.size()); else pass_cnt++;
        total_cnt++;
    endtask

    // Final sck rise and cs rise hit the pins together.
    task automatic test_collision();
        logic [7:0] ra, rb;
        int cv0;
        rd_q_a.delete();
        cs_begin();
        send(8'h03); send(8'h00); send(8'h01);
        spi_bits(8'h00, 7, ra, rb);
        mosi_drv = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        sck_drv = 1'b1;
        cs_drv  = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 sck_drv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        if (rd_q_a.size() !== 0) $display("FAIL collide_addr_no_mem_rd: got %0d reads expected 0", rd_q_a.size()); else pass_cnt++;
        total_cnt++;
        if (bus_a.spi_miso_oe !== 1'b0) $display("FAIL collide_oe: got %b expected 0", bus_a.spi_miso_oe); else pass_cnt++;
        total_cnt++;
        cv0 = cv_cnt_a;
        cs_begin();
        spi_bits(8'h9F, 7, ra, rb);
        mosi_drv = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        sck_drv = 1'b1;
        cs_drv  = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 sck_drv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        if (cv_cnt_a - cv0 !== 0) $display("FAIL collide_cmd_valid: got %0d pulses expected 0", cv_cnt_a - cv0); else pass_cnt++;
        total_cnt++;
        if (bus_a.cmd_byte !== 8'h03) $display("FAIL collide_cmd_byte: got %02h expected 03", bus_a.cmd_byte); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] ra, rb;
        int cv0;
        cs_begin();
        send(8'h03); send(8'h00);
        spi_bits(8'h12, 4, ra, rb);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (bus_a.spi_miso !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", bus_a.spi_miso); else pass_cnt++;
        total_cnt++;
        if (bus_a.spi_miso_oe !== 1'b0) $display("FAIL rstmid_oe: got %b expected 0", bus_a.spi_miso_oe); else pass_cnt++;
        total_cnt++;
        if (bus_a.mem_addr !== 24'h0) $display("FAIL rstmid_mem_addr: got %h expected 000000", bus_a.mem_addr); else pass_cnt++;
        total_cnt++;
        if (bus_a.cmd_byte !== 8'h00) $display("FAIL rstmid_cmd_byte: got %02h expected 00", bus_a.cmd_byte); else pass_cnt++;
        total_cnt++;
        reset = 1'b0;
        cv0 = cv_cnt_a;
        spi_bits(8'h9F, 8, ra, rb);
        spi_bits(8'h00, 8, ra, rb);
        if (bus_a.spi_miso_oe !== 1'b0) $display("FAIL rstmid_stays_idle_oe: got %b expected 0", bus_a.spi_miso_oe); else pass_cnt++;
        total_cnt++;
        if (cv_cnt_a - cv0 !== 0) $display("FAIL rstmid_no_cmd: got %0d pulses expected 0", cv_cnt_a - cv0); else pass_cnt++;
        total_cnt++;
        cs_end();
        cs_begin();
        send(8'hAB); send(8'h00); send(8'h00); send(8'h00);
        spi_bits(8'h00, 8, ra, rb);
        if (ra !== 8'h15) $display("FAIL res_devid_a: got %02h expected 15", ra); else pass_cnt++;
        total_cnt++;
        spi_bits(8'h00, 8, ra, rb);
        if (rb !== 8'h15) $display("FAIL res_devid_repeat_b: got %02h expected 15", rb); else pass_cnt++;
        total_cnt++;
        cs_end();
        if (bus_a.cmd_byte !== 8'hAB) $display("FAIL res_cmd_byte: got %02h expected ab", bus_a.cmd_byte); else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        cv_cnt_a   = 0;
        cs_drv     = 1'b1;
        sck_drv    = 1'b0;
        mosi_drv   = 1'b0;
        status_val = 8'h00;
        reset      = 1'b1;
        test_reset();
        test_rdid();
        test_read();
        test_wrap();
        test_status();
        test_ignore();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
